// File: rtl/lcd_text_pkg.sv
// Shared definitions for the button-driven text writer.
// Holds the default screen geometry, the character range cycled through
// on each press, the writer FSM states and the button event types. Both
// the writer and its debounce front end import this package.
`timescale 1ns/1ps

package lcd_text_pkg;

  // Number of bits needed to index n items. Never returns less than 1, so
  // degenerate geometries still get a real signal.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Default geometry: 800x480 pixels with 8x16 character cells.
  localparam int unsigned COLS   = 100;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = bits_for(CELLS);

  // Character codes.
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] FIRST_CHAR = 8'h20;
  localparam logic [7:0] LAST_CHAR  = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_ADVANCE
  } wr_state_t;

  typedef enum logic [1:0] {
    EVT_NONE,
    EVT_CHAR,
    EVT_NEWLINE
  } evt_t;

endpackage

// File: rtl/button_debounce.sv
// Button front end: synchroniser, debouncer and short/long press classifier.
// Ports:
//   i_clk          clock
//   i_rst          asynchronous active-high reset
//   i_button       raw, asynchronous, bouncing button
//   o_charEvt      one-cycle pulse when a short press is released
//   o_newlineEvt   one-cycle pulse when a press has been held long enough
`timescale 1ns/1ps

module button_debounce #(
  parameter int unsigned DB_CYCLES      = 330_000,
  parameter int unsigned LONG_CYCLES    = 16_500_000,
  parameter bit          BTN_ACTIVE_LOW = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_charEvt,
  output logic o_newlineEvt
);
  import lcd_text_pkg::*;

  localparam int unsigned DB_MAX   = (DB_CYCLES   < 1) ? 1 : DB_CYCLES;
  localparam int unsigned LONG_MAX = (LONG_CYCLES < 1) ? 1 : LONG_CYCLES;
  localparam int unsigned DB_W     = bits_for(DB_MAX);
  localparam int unsigned HOLD_W   = bits_for(LONG_MAX + 1);

  logic              r_syncMeta;
  logic              r_syncOut;
  logic              r_stable;
  logic [DB_W-1:0]   r_dbCnt;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_charEvt;
  logic              r_newlineEvt;
  logic              w_level;
  logic              w_flip;

  // Two-flop synchroniser. Resetting to the idle line level keeps the
  // debouncer from seeing a phantom press right after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_syncMeta <= BTN_ACTIVE_LOW;
      r_syncOut  <= BTN_ACTIVE_LOW;
    end else begin
      r_syncMeta <= i_button;
      r_syncOut  <= r_syncMeta;
    end
  end

  // Normalised level: 1 means pressed regardless of wiring.
  assign w_level = r_syncOut ^ BTN_ACTIVE_LOW;
  // The stable level flips on the DB_MAX-th consecutive disagreeing sample.
  assign w_flip  = (w_level != r_stable) && (r_dbCnt == DB_W'(DB_MAX - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_dbCnt  <= '0;
    end else if (w_level == r_stable) begin
      r_dbCnt <= '0;
    end else if (w_flip) begin
      r_stable <= w_level;
      r_dbCnt  <= '0;
    end else begin
      r_dbCnt <= r_dbCnt + 1'b1;
    end
  end

  // Hold counter saturates at LONG_MAX so a long press pulses newline exactly
  // once and its eventual release is recognised as "already handled".
  // A release only counts as a character if the newline threshold was not
  // reached, including on the very cycle of release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_holdCnt    <= '0;
      r_charEvt    <= 1'b0;
      r_newlineEvt <= 1'b0;
    end else begin
      r_charEvt    <= 1'b0;
      r_newlineEvt <= 1'b0;
      if (r_stable) begin
        if (r_holdCnt != HOLD_W'(LONG_MAX)) begin
          r_holdCnt <= r_holdCnt + 1'b1;
          if (r_holdCnt == HOLD_W'(LONG_MAX - 1)) begin
            r_newlineEvt <= 1'b1;
          end
        end
        if (w_flip && (r_holdCnt < HOLD_W'(LONG_MAX - 1))) begin
          r_charEvt <= 1'b1;
        end
      end else begin
        r_holdCnt <= '0;
      end
    end
  end

  assign o_charEvt    = r_charEvt;
  assign o_newlineEvt = r_newlineEvt;

endmodule

// File: rtl/button_text_writer.sv
// Turns button presses into writes to the character-cell text RAM.
// After reset every cell is cleared to a space; then each short press writes
// the next printable character at the cursor and advances it, and each long
// press moves the cursor to the start of the next row.
// Ports:
//   PixelClk      the only clock
//   Reset_Button  asynchronous active-high reset
//   User_Button   raw button input
//   Wr_Ready      text RAM accepts the write this cycle
//   Wr_En         write request, held until accepted
//   Wr_Addr       linear cell address (row*COLS+col)
//   Wr_Data       character code
//   Cursor_Col    current cursor column
//   Cursor_Row    current cursor row
//   Busy          high while the screen clear is running
`timescale 1ns/1ps

module button_text_writer #(
  parameter int unsigned CLK_HZ         = 33_000_000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned LONG_PRESS_MS  = 500,
  parameter int unsigned COLS           = lcd_text_pkg::COLS,
  parameter int unsigned ROWS           = lcd_text_pkg::ROWS,
  parameter logic [7:0]  FIRST_CHAR     = lcd_text_pkg::FIRST_CHAR,
  parameter logic [7:0]  LAST_CHAR      = lcd_text_pkg::LAST_CHAR,
  parameter bit          BTN_ACTIVE_LOW = 1'b0,
  localparam int unsigned ADDR_W = lcd_text_pkg::bits_for(COLS * ROWS),
  localparam int unsigned COL_W  = lcd_text_pkg::bits_for(COLS),
  localparam int unsigned ROW_W  = lcd_text_pkg::bits_for(ROWS)
) (
  input  logic              PixelClk,
  input  logic              Reset_Button,
  input  logic              User_Button,
  input  logic              Wr_Ready,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [7:0]        Wr_Data,
  output logic [COL_W-1:0]  Cursor_Col,
  output logic [ROW_W-1:0]  Cursor_Row,
  output logic              Busy
);
  import lcd_text_pkg::*;

  localparam int unsigned NUM_CELLS   = COLS * ROWS;
  localparam int unsigned DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYCLES = CLK_HZ / 1000 * LONG_PRESS_MS;

  wr_state_t         r_state,     w_stateNext;
  logic              r_wrEn,      w_wrEnNext;
  logic [ADDR_W-1:0] r_wrAddr,    w_wrAddrNext;
  logic [7:0]        r_wrData,    w_wrDataNext;
  logic              r_busy,      w_busyNext;
  logic [COL_W-1:0]  r_col,       w_colNext;
  logic [ROW_W-1:0]  r_row,       w_rowNext;
  logic [ADDR_W-1:0] r_rowBase,   w_rowBaseNext;
  logic [7:0]        r_nextChar,  w_nextCharNext;
  logic              r_pendValid, w_pendValidNext;
  evt_t              r_pendType,  w_pendTypeNext;

  logic              w_charEvt;
  logic              w_newlineEvt;
  evt_t              w_evt;
  evt_t              w_cur;
  logic              w_lastRow;
  logic [ROW_W-1:0]  w_rowInc;
  logic [ADDR_W-1:0] w_rowBaseInc;

  button_debounce #(
    .DB_CYCLES      (DB_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_debounce (
    .i_clk        (PixelClk),
    .i_rst        (Reset_Button),
    .i_button     (User_Button),
    .o_charEvt    (w_charEvt),
    .o_newlineEvt (w_newlineEvt)
  );

  // All writer state lives in this one register bank.
  always_ff @(posedge PixelClk or posedge Reset_Button) begin
    if (Reset_Button) begin
      r_state     <= ST_CLEAR;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= CHAR_SPACE;
      r_busy      <= 1'b1;
      r_col       <= '0;
      r_row       <= '0;
      r_rowBase   <= '0;
      r_nextChar  <= FIRST_CHAR;
      r_pendValid <= 1'b0;
      r_pendType  <= EVT_NONE;
    end else begin
      r_state     <= w_stateNext;
      r_wrEn      <= w_wrEnNext;
      r_wrAddr    <= w_wrAddrNext;
      r_wrData    <= w_wrDataNext;
      r_busy      <= w_busyNext;
      r_col       <= w_colNext;
      r_row       <= w_rowNext;
      r_rowBase   <= w_rowBaseNext;
      r_nextChar  <= w_nextCharNext;
      r_pendValid <= w_pendValidNext;
      r_pendType  <= w_pendTypeNext;
    end
  end

  // Moving to the next row wraps to row 0. The row base address is kept
  // alongside the row so the cell address needs only an adder.
  assign w_lastRow    = (r_row == ROW_W'(ROWS - 1));
  assign w_rowInc     = w_lastRow ? '0 : r_row + 1'b1;
  assign w_rowBaseInc = w_lastRow ? '0 : r_rowBase + ADDR_W'(COLS);

  // Next-state logic. Events arriving while a write is in flight are parked
  // in a one-deep pending slot; anything beyond that is dropped. Events
  // during the clear sweep are ignored entirely.
  always_comb begin
    w_stateNext     = r_state;
    w_wrEnNext      = r_wrEn;
    w_wrAddrNext    = r_wrAddr;
    w_wrDataNext    = r_wrData;
    w_busyNext      = r_busy;
    w_colNext       = r_col;
    w_rowNext       = r_row;
    w_rowBaseNext   = r_rowBase;
    w_nextCharNext  = r_nextChar;
    w_pendValidNext = r_pendValid;
    w_pendTypeNext  = r_pendType;
    w_cur           = EVT_NONE;
    w_evt           = w_charEvt    ? EVT_CHAR    :
                      w_newlineEvt ? EVT_NEWLINE : EVT_NONE;

    case (r_state)
      ST_CLEAR: begin
        w_wrEnNext   = 1'b1;
        w_wrDataNext = CHAR_SPACE;
        if (r_wrEn && Wr_Ready) begin
          if (r_wrAddr == ADDR_W'(NUM_CELLS - 1)) begin
            w_wrEnNext  = 1'b0;
            w_busyNext  = 1'b0;
            w_stateNext = ST_IDLE;
          end else begin
            w_wrAddrNext = r_wrAddr + 1'b1;
          end
        end
      end

      ST_IDLE: begin
        if (r_pendValid) begin
          w_cur           = r_pendType;
          w_pendValidNext = (w_evt != EVT_NONE);
          w_pendTypeNext  = w_evt;
        end else begin
          w_cur = w_evt;
        end
        if (w_cur == EVT_CHAR) begin
          w_stateNext  = ST_WRITE;
          w_wrEnNext   = 1'b1;
          w_wrAddrNext = r_rowBase + ADDR_W'(r_col);
          w_wrDataNext = r_nextChar;
        end else if (w_cur == EVT_NEWLINE) begin
          w_colNext     = '0;
          w_rowNext     = w_rowInc;
          w_rowBaseNext = w_rowBaseInc;
        end
      end

      ST_WRITE: begin
        if (!r_pendValid && (w_evt != EVT_NONE)) begin
          w_pendValidNext = 1'b1;
          w_pendTypeNext  = w_evt;
        end
        if (Wr_Ready) begin
          w_wrEnNext  = 1'b0;
          w_stateNext = ST_ADVANCE;
        end
      end

      ST_ADVANCE: begin
        if (!r_pendValid && (w_evt != EVT_NONE)) begin
          w_pendValidNext = 1'b1;
          w_pendTypeNext  = w_evt;
        end
        if (r_col == COL_W'(COLS - 1)) begin
          w_colNext     = '0;
          w_rowNext     = w_rowInc;
          w_rowBaseNext = w_rowBaseInc;
        end else begin
          w_colNext = r_col + 1'b1;
        end
        w_nextCharNext = (r_nextChar == LAST_CHAR) ? FIRST_CHAR : r_nextChar + 8'd1;
        w_stateNext    = ST_IDLE;
      end

      default: begin
        w_stateNext = ST_CLEAR;
      end
    endcase
  end

  assign Wr_En      = r_wrEn;
  assign Wr_Addr    = r_wrAddr;
  assign Wr_Data    = r_wrData;
  assign Cursor_Col = r_col;
  assign Cursor_Row = r_row;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_button_text_writer.sv
// Self-checking bench for button_text_writer on a 4x2 screen at 100 kHz.
// A reference model tracks the cursor and next character as plain integers
// and predicts every accepted write; a monitor records what the DUT
// actually hands to the text RAM.
`timescale 1ns/1ps

module tb_button_text_writer;

  localparam int         TB_COLS  = 4;
  localparam int         TB_ROWS  = 2;
  localparam int         TB_CELLS = TB_COLS * TB_ROWS;
  localparam logic [7:0] FIRST    = 8'h20;
  localparam logic [7:0] LAST     = 8'h7E;

  logic       PixelClk     = 1'b0;
  logic       Reset_Button = 1'b1;
  logic       User_Button  = 1'b0;
  logic       Wr_Ready     = 1'b1;
  logic       Wr_En;
  logic [2:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic [1:0] Cursor_Col;
  logic [0:0] Cursor_Row;
  logic       Busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;
  int readyMode   = 0;

  int gotAddr[$];
  int gotData[$];
  int gotCycle[$];
  int expAddr[$];
  int expData[$];

  int         mCol;
  int         mRow;
  logic [7:0] mChar;

  button_text_writer #(
    .CLK_HZ         (100_000),
    .DEBOUNCE_MS    (1),
    .LONG_PRESS_MS  (50),
    .COLS           (TB_COLS),
    .ROWS           (TB_ROWS),
    .FIRST_CHAR     (8'h20),
    .LAST_CHAR      (8'h7E),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .PixelClk     (PixelClk),
    .Reset_Button (Reset_Button),
    .User_Button  (User_Button),
    .Wr_Ready     (Wr_Ready),
    .Wr_En        (Wr_En),
    .Wr_Addr      (Wr_Addr),
    .Wr_Data      (Wr_Data),
    .Cursor_Col   (Cursor_Col),
    .Cursor_Row   (Cursor_Row),
    .Busy         (Busy)
  );

  // 100 MHz nominal period; only cycle counts matter.
  always #5 PixelClk = ~PixelClk;

  always @(posedge PixelClk) cycle++;

  // Text RAM readiness: always, never, or 70 % of cycles.
  always @(posedge PixelClk) begin
    #1;
    case (readyMode)
      0:       Wr_Ready = 1'b1;
      1:       Wr_Ready = 1'b0;
      default: Wr_Ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Record every write the RAM accepts.
  always @(negedge PixelClk) begin
    if (!Reset_Button && Wr_En && Wr_Ready) begin
      gotAddr.push_back(int'(Wr_Addr));
      gotData.push_back(int'(Wr_Data));
      gotCycle.push_back(cycle);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to be done", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PixelClk);
      #1;
    end
  endtask

  // Reference model: cursor walks row-major, wraps at the screen end,
  // characters cycle FIRST..LAST.
  function automatic void modelReset();
    mCol  = 0;
    mRow  = 0;
    mChar = FIRST;
    for (int i = 0; i < TB_CELLS; i++) begin
      expAddr.push_back(i);
      expData.push_back(int'(FIRST));
    end
  endfunction

  function automatic void modelChar();
    expAddr.push_back(mRow * TB_COLS + mCol);
    expData.push_back(int'(mChar));
    mCol++;
    if (mCol == TB_COLS) begin
      mCol = 0;
      mRow = (mRow + 1) % TB_ROWS;
    end
    mChar = (mChar == LAST) ? FIRST : mChar + 8'd1;
  endfunction

  function automatic void modelNewline();
    mCol = 0;
    mRow = (mRow + 1) % TB_ROWS;
  endfunction

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_count"}, gotAddr.size(), expAddr.size());
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checkOutput({tag, "_addr"}, gotAddr[i], expAddr[i]);
      checkOutput({tag, "_data"}, gotData[i], expData[i]);
    end
    gotAddr.delete();
    gotData.delete();
    gotCycle.delete();
    expAddr.delete();
    expData.delete();
    checkOutput({tag, "_col"}, Cursor_Col, mCol);
    checkOutput({tag, "_row"}, Cursor_Row, mRow);
  endtask

  task automatic applyStimulus(input int holdCycles, input int gapCycles);
    User_Button = 1'b1;
    tick(holdCycles);
    User_Button = 1'b0;
    tick(gapCycles);
  endtask

  task automatic waitClear(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_busyDone"}, Busy, 0);
  endtask

  task automatic waitWrEn(input string tag);
    int n = 0;
    while (Wr_En !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    checkOutput(tag, Wr_En, 1);
  endtask

  initial begin
    int nlIdx;
    int bad;
    int sAddr;
    int sData;

    // Reset values while reset is held.
    tick(3);
    checkOutput("rst_wrEn", Wr_En, 0);
    checkOutput("rst_addr", Wr_Addr, 0);
    checkOutput("rst_data", Wr_Data, 8'h20);
    checkOutput("rst_busy", Busy, 1);
    checkOutput("rst_col", Cursor_Col, 0);
    checkOutput("rst_row", Cursor_Row, 0);

    // Clear sweep: 8 spaces on back-to-back cycles.
    modelReset();
    Reset_Button = 1'b0;
    waitClear("clear");
    if (gotCycle.size() == TB_CELLS)
      checkOutput("clear_consecutive", gotCycle[TB_CELLS-1] - gotCycle[0], TB_CELLS - 1);
    else
      checkOutput("clear_consecutive", gotCycle.size(), TB_CELLS);
    checkWrites("clear");

    // Two clean 5 ms presses.
    applyStimulus(500, 300);
    modelChar();
    checkWrites("press1");
    applyStimulus(500, 300);
    modelChar();
    checkWrites("press2");

    // Bouncing contact for 300 cycles, then a clean hold.
    for (int k = 0; k < 15; k++) begin
      User_Button = (k % 2 == 0);
      tick(20);
    end
    checkOutput("bounce_noWrite", gotAddr.size(), 0);
    User_Button = 1'b1;
    tick(300);
    User_Button = 1'b0;
    tick(300);
    modelChar();
    checkWrites("bounce");

    // 60 ms hold: newline around 5100 cycles in, no write, silent release.
    User_Button = 1'b1;
    tick(5050);
    checkOutput("long_early_col", Cursor_Col, mCol);
    checkOutput("long_early_row", Cursor_Row, mRow);
    tick(150);
    modelNewline();
    checkOutput("long_fired_col", Cursor_Col, mCol);
    checkOutput("long_fired_row", Cursor_Row, mRow);
    tick(800);
    User_Button = 1'b0;
    tick(300);
    checkWrites("long");

    // Back to the top row, then fill the screen and wrap the cursor.
    applyStimulus(5200, 300);
    modelNewline();
    checkWrites("long2");
    for (int i = 0; i < TB_CELLS; i++) begin
      applyStimulus(200, 250);
      modelChar();
    end
    checkWrites("wrap8");

    // Random presses with a randomly stalling RAM; long enough to wrap
    // the character code past LAST.
    readyMode = 2;
    nlIdx = $urandom_range(10, 80);
    for (int i = 0; i < 90; i++) begin
      if (i == nlIdx) begin
        applyStimulus(5200, 300);
        modelNewline();
      end else begin
        applyStimulus($urandom_range(130, 250), $urandom_range(220, 300));
        modelChar();
      end
      checkWrites("rand");
    end

    // Stalled RAM: request holds steady, one event is queued, one dropped.
    readyMode = 1;
    tick(2);
    sAddr = mRow * TB_COLS + mCol;
    sData = int'(mChar);
    User_Button = 1'b1;
    tick(200);
    User_Button = 1'b0;
    waitWrEn("stall_wrEn");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (Wr_En !== 1'b1 || int'(Wr_Addr) != sAddr || int'(Wr_Data) != sData) bad++;
    end
    checkOutput("stall_stable", bad, 0);
    checkOutput("stall_addr", Wr_Addr, sAddr);
    checkOutput("stall_data", Wr_Data, sData);
    applyStimulus(200, 250);
    applyStimulus(200, 250);
    checkOutput("stall_still_en", Wr_En, 1);
    checkOutput("stall_still_addr", Wr_Addr, sAddr);
    readyMode = 0;
    tick(50);
    modelChar();
    modelChar();
    checkWrites("stall");

    // Reset in the middle of a stalled write.
    readyMode = 1;
    tick(2);
    User_Button = 1'b1;
    tick(200);
    User_Button = 1'b0;
    waitWrEn("midRst_pre");
    Reset_Button = 1'b1;
    #1;
    checkOutput("midRst_wrEn", Wr_En, 0);
    checkOutput("midRst_busy", Busy, 1);
    checkOutput("midRst_addr", Wr_Addr, 0);
    readyMode = 0;
    tick(4);
    gotAddr.delete();
    gotData.delete();
    gotCycle.delete();
    expAddr.delete();
    expData.delete();
    modelReset();
    Reset_Button = 1'b0;
    waitClear("reclear");
    checkWrites("reclear");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
